// File: rtl/sha256_block_sequencer.sv
// rtl/sha256_block_sequencer.sv - SHA-256 front end: byte packing, FIPS 180-4 padding, block issue, digest streaming
// Optional watchdog on the core handshake: define SHA256_SEQ_WATCHDOG_EN.
`timescale 1ns/1ps

module sha256_block_sequencer #(
    parameter int LEN_W       = 32,
    parameter int WDOG_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         blk_we,
    output logic [3:0]   blk_addr,
    output logic [31:0]  blk_data,
    output logic         core_start,
    output logic         core_init,
    input  logic         core_done,
    input  logic [255:0] core_digest,
    output logic         out_valid,
    output logic [7:0]   out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy,
    output logic         err
);

    // The length field is 64 bits wide and the watchdog needs at least two
    // cycles to distinguish START from an expired WAIT.
    generate
        if (LEN_W > 61 || WDOG_CYCLES < 2) begin : g_param_check
            $error("sha256_block_sequencer: need LEN_W <= 61 and WDOG_CYCLES >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABSORB,
        S_PAD,
        S_LEN,
        S_START,
        S_WAIT,
        S_DIGEST
    } state_t;

    state_t           state;
    state_t           state_n;
    state_t           ret_state;   // where to resume once the core finishes a block
    state_t           ret_n;

    logic [6:0]       pos;         // byte position inside the current block, 0..64
    logic [LEN_W-1:0] byte_count;  // accepted message bytes
    logic             first_blk;   // next block starts a new message (use IV)
    logic             pad_sent;    // the 0x80 marker has been emitted
    logic [23:0]      word_reg;    // the three most recent bytes of the current word
    logic [4:0]       dig_idx;     // digest byte index, 0 = H0 MSB

    logic             accept;
    logic             byte_take;
    logic [7:0]       byte_val;
    logic             pos_last;
    logic             digest_done;
    logic             wd_expire;
    logic [63:0]      bit_len;

    assign pos_last = (pos == 7'd63);
    assign bit_len  = 64'({byte_count, 3'b000});
    assign busy     = (state != S_IDLE);

`ifdef SHA256_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wdog_cnt;
    logic            err_q;

    // Expire when the WAIT cycle about to end would be the WDOG_CYCLES-th since core_start.
    assign wd_expire = (state == S_WAIT) && !core_done &&
                       (wdog_cnt >= WD_W'(WDOG_CYCLES - 1));
    assign err       = err_q;

    // Cycle counter for the core handshake and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == S_START) begin
                wdog_cnt <= WD_W'(1);
            end else if (state == S_WAIT) begin
                wdog_cnt <= wdog_cnt + WD_W'(1);
            end
            if (wd_expire) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    // State register and the recorded return path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
        end else begin
            state     <= state_n;
            ret_state <= ret_n;
        end
    end

    // Next state, byte source selection and all handshake outputs.
    always_comb begin
        state_n     = state;
        ret_n       = ret_state;
        in_ready    = 1'b0;
        accept      = 1'b0;
        byte_take   = 1'b0;
        byte_val    = 8'h00;
        blk_we      = 1'b0;
        blk_addr    = 4'd0;
        blk_data    = 32'd0;
        core_start  = 1'b0;
        core_init   = 1'b0;
        out_valid   = 1'b0;
        out_data    = 8'h00;
        out_last    = 1'b0;
        digest_done = 1'b0;

        case (state)
            S_IDLE, S_ABSORB: begin
                in_ready  = 1'b1;
                accept    = in_valid;
                byte_take = in_valid;
                byte_val  = in_data;
                if (in_valid) begin
                    if (pos_last) begin
                        state_n = S_START;
                        ret_n   = in_last ? S_PAD : S_ABSORB;
                    end else if (in_last) begin
                        state_n = S_PAD;
                    end else begin
                        state_n = S_ABSORB;
                    end
                end
            end
            S_PAD: begin
                byte_take = 1'b1;
                byte_val  = pad_sent ? 8'h00 : 8'h80;
                if (pos_last) begin
                    state_n = S_START;
                    ret_n   = S_PAD;
                end else if (pos == 7'd55) begin
                    // Any PAD byte written at 55 means the marker is already out.
                    state_n = S_LEN;
                end
            end
            S_LEN: begin
                // pos 56..63 maps to length bytes 7..0 (MSB first).
                byte_take = 1'b1;
                byte_val  = bit_len[{~pos[2:0], 3'b000} +: 8];
                if (pos_last) begin
                    state_n = S_START;
                    ret_n   = S_LEN;
                end
            end
            S_START: begin
                core_start = 1'b1;
                core_init  = first_blk;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    state_n = (ret_state == S_LEN) ? S_DIGEST : ret_state;
                end else if (wd_expire) begin
                    state_n = S_IDLE;
                end
            end
            S_DIGEST: begin
                out_valid = 1'b1;
                out_data  = core_digest[{~dig_idx, 3'b000} +: 8];
                out_last  = (dig_idx == 5'd31);
                if (out_ready && out_last) begin
                    digest_done = 1'b1;
                    state_n     = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Every fourth byte completes a big-endian word for the core.
        if (byte_take && (pos[1:0] == 2'b11)) begin
            blk_we   = 1'b1;
            blk_addr = pos[5:2];
            blk_data = {word_reg, byte_val};
        end
    end

    // Block position, packing register, message length and block bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos        <= 7'd0;
            byte_count <= '0;
            first_blk  <= 1'b1;
            pad_sent   <= 1'b0;
            word_reg   <= 24'd0;
            dig_idx    <= 5'd0;
        end else begin
            if (byte_take) begin
                word_reg <= {word_reg[15:0], byte_val};
                pos      <= pos + 7'd1;
            end
            if (accept) begin
                byte_count <= byte_count + LEN_W'(1);
            end
            if (state == S_PAD) begin
                pad_sent <= 1'b1;
            end
            if ((state == S_WAIT) && core_done) begin
                pos       <= 7'd0;
                first_blk <= 1'b0;
            end
            if ((state == S_DIGEST) && out_ready) begin
                dig_idx <= dig_idx + 5'd1;
            end
            // End of message or abandoned block: back to a clean message start.
            if (digest_done || wd_expire) begin
                pos        <= 7'd0;
                byte_count <= '0;
                first_blk  <= 1'b1;
                pad_sent   <= 1'b0;
            end
        end
    end

endmodule
